md_scheduler: RTL and testbench

- Sequences the multiply/divide resource used by the execute stage.
- Accepts MD-class operations from E, computes the 64-bit result at issue, and holds it pending for a fixed latency before committing it to the architectural Hi/Lo registers.
- Generates the decode-stage stall for MD-class instructions while an operation is in flight.
- Suppresses issue and Hi/Lo writes when E is being killed by an exception or eret.

---
 rtl/md_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_md_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the execute stage: computes the 64-bit result at
// issue, holds it for a fixed latency, then commits it to the architectural Hi/Lo.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        kill,
  input  logic        md_use_d,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        accept;
  logic        issue;
  logic        is_div;
  logic [63:0] result;

  function automatic logic [63:0] mult_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a_x;
    logic signed [63:0] b_x;
    logic signed [63:0] p;
    a_x = {{32{a[31]}}, a};
    b_x = {{32{b[31]}}, b};
    p   = a_x * b_x;
    return p;
  endfunction

  function automatic logic [63:0] mult_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a_x;
    logic [63:0] b_x;
    a_x = {32'd0, a};
    b_x = {32'd0, b};
    return a_x * b_x;
  endfunction

  // Divide on magnitudes, then fix signs: quotient truncates toward zero and the
  // remainder follows the dividend. 0x8000_0000 / -1 falls out naturally as 0x8000_0000 r 0.
  function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] res;
    a_neg = is_signed & a[31];
    b_neg = is_signed & b[31];
    mag_a = a_neg ? (~a + 32'd1) : a;
    mag_b = b_neg ? (~b + 32'd1) : b;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
      if (a_neg ^ b_neg) q = ~q + 32'd1;
      if (a_neg)         r = ~r + 32'd1;
      res = {r, q};
    end
    return res;
  endfunction

  assign accept = op_valid & ~kill;
  assign issue  = accept & (state_q == IDLE) & ~op[2];
  assign is_div = op[1];

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = mult_signed(src_a, src_b);
      OP_MULTU: result = mult_unsigned(src_a, src_b);
      OP_DIV:   result = divide(src_a, src_b, 1'b1);
      OP_DIVU:  result = divide(src_a, src_b, 1'b0);
      default:  result = 64'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          pend_hi_d = result[63:32];
          pend_lo_d = result[31:0];
          cnt_d     = is_div ? DIV_LD : MULT_LD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // An explicit Hi/Lo write supersedes anything in flight, including a same-edge commit.
    if (accept && (op == OP_MTHI || op == OP_MTLO)) begin
      hi_d      = (op == OP_MTHI) ? src_a : hi_q;
      lo_d      = (op == OP_MTLO) ? src_a : lo_q;
      state_d   = IDLE;
      cnt_d     = '0;
      pend_hi_d = 32'd0;
      pend_lo_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = md_use_d & (busy | issue);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    rd_data = 32'd0;
    if (op == OP_MFHI) rd_data = hi_q;
    if (op == OP_MFLO) rd_data = lo_q;
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: a vector table of MD operations plus
// hand-written sequences for kill, abort, ignored issue and reset corner cases.
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        md_use_d;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .kill     (kill),
    .md_use_d (md_use_d),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic k);
    op_valid = v;
    op       = o;
    src_a    = a;
    src_b    = b;
    kill     = k;
    #1;
  endtask

  initial begin
    vec[0] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vec[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
    vec[2] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vec[3] = '{3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, DC};
    vec[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
    vec[5] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
    vec[6] = '{3'b010, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DC};
    vec[7] = '{3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MC};
    vec[8] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, DC};
    vec[9] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};

    reset    = 1'b1;
    md_use_d = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rd", rd_data, 32'd0);

    for (int i = 0; i < 10; i++) begin
      md_use_d = 1'b1;
      drive(1'b1, vec[i].op, vec[i].a, vec[i].b, 1'b0);
      chk($sformatf("v%0d_stall_issue", i), 32'(stall), 32'd1);
      tick();
      drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      for (int c = 0; c < vec[i].cyc; c++) begin
        chk($sformatf("v%0d_busy_c%0d", i, c + 1), 32'(busy), 32'd1);
        chk($sformatf("v%0d_stall_c%0d", i, c + 1), 32'(stall), 32'd1);
        tick();
      end
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_stall_end", i), 32'(stall), 32'd0);
      chk($sformatf("v%0d_hi", i), hi, vec[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vec[i].exp_lo);
      md_use_d = 1'b0;
      drive(1'b1, 3'b110, 32'd0, 32'd0, 1'b0);
      chk($sformatf("v%0d_mfhi", i), rd_data, vec[i].exp_hi);
      drive(1'b1, 3'b111, 32'd0, 32'd0, 1'b0);
      chk($sformatf("v%0d_mflo", i), rd_data, vec[i].exp_lo);
      drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    end

    // mthi / mtlo, each leaving the other register alone
    drive(1'b1, 3'b100, 32'hA5A5_A5A5, 32'd0, 1'b0);
    tick();
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo", lo, 32'h0000_0000);
    drive(1'b1, 3'b101, 32'h5A5A_5A5A, 32'd0, 1'b0);
    tick();
    chk("mtlo_hi", hi, 32'hA5A5_A5A5);
    chk("mtlo_lo", lo, 32'h5A5A_5A5A);

    // killed mult and killed mthi do nothing
    md_use_d = 1'b1;
    drive(1'b1, 3'b000, 32'd2, 32'd3, 1'b1);
    chk("kill_stall", 32'(stall), 32'd0);
    tick();
    chk("kill_busy", 32'(busy), 32'd0);
    drive(1'b1, 3'b100, 32'h0000_0000, 32'd0, 1'b1);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    for (int c = 0; c < MC + 1; c++) tick();
    chk("kill_hi", hi, 32'hA5A5_A5A5);
    chk("kill_lo", lo, 32'h5A5A_5A5A);

    // md_use_d low: never stall; a div presented mid-busy is ignored
    md_use_d = 1'b0;
    drive(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
    chk("nouse_stall_issue", 32'(stall), 32'd0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    for (int c = 1; c <= MC; c++) begin
      chk($sformatf("nouse_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("nouse_stall_c%0d", c), 32'(stall), 32'd0);
      if (c == 2) drive(1'b1, 3'b010, 32'd100, 32'd7, 1'b0);
      tick();
      drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    end
    chk("ignored_busy_end", 32'(busy), 32'd0);
    chk("ignored_hi", hi, 32'd0);
    chk("ignored_lo", lo, 32'd12);

    // kill during busy cycle 2 of a div: still commits after 10 cycles, blocked mtlo
    md_use_d = 1'b1;
    drive(1'b1, 3'b010, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    drive(1'b1, 3'b101, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("kbusy_stall_c2", 32'(stall), 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    for (int c = 3; c <= DC; c++) begin
      chk($sformatf("kbusy_busy_c%0d", c), 32'(busy), 32'd1);
      tick();
    end
    chk("kbusy_busy_end", 32'(busy), 32'd0);
    chk("kbusy_hi", hi, 32'd2);
    chk("kbusy_lo", lo, 32'd14);

    // mthi in busy cycle 3 aborts the div
    drive(1'b1, 3'b010, 32'd50, 32'd7, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    chk("abort_busy_c3", 32'(busy), 32'd1);
    drive(1'b1, 3'b100, 32'h0000_1234, 32'd0, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'h0000_1234);
    chk("abort_lo", lo, 32'd14);
    for (int c = 0; c < DC + 2; c++) tick();
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_hi", hi, 32'h0000_1234);
    chk("abort_late_lo", lo, 32'd14);

    // reset in the middle of a mult: no commit afterwards
    drive(1'b1, 3'b000, 32'd3, 32'd4, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < MC + 2; c++) tick();
    chk("midrst_late_busy", 32'(busy), 32'd0);
    chk("midrst_late_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
